// File: rtl/ga_selection.sv
// Elitist selection: scans N_POP candidates one per cycle and keeps the N_SEL lowest-cost paths
// in a sorted insertion list. Optional path de-duplication via `SELECTION_DEDUP_EN.

module ga_sel_slot #(
    parameter int FIT_W = 16
) (
    input  logic             valid,
    input  logic [FIT_W-1:0] cost,
    input  logic [FIT_W-1:0] cand_cost,
    output logic             le
);
    // Invalid entries behave as +inf, so they never rank ahead of a candidate.
    assign le = valid && (cost <= cand_cost);
endmodule

module ga_selection #(
    parameter int N_POP  = 50,
    parameter int N_SEL  = 10,
    parameter int PATH_W = 150,
    parameter int FIT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [N_POP*PATH_W-1:0] population,
    input  logic [N_POP*FIT_W-1:0]  fitness,
    output logic [N_SEL*PATH_W-1:0] sel_population,
    output logic [FIT_W-1:0]        best_fitness,
    output logic                    done
);
    localparam int IDX_W = $clog2(N_POP);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POP - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    typedef struct packed {
        logic             vld;
        logic [FIT_W-1:0] cost;
        logic [PATH_W-1:0] path;
    } entry_t;

    state_t state, state_nxt;
    logic [IDX_W-1:0] idx;
    entry_t [N_SEL-1:0] lst, lst_nxt;
    logic [N_SEL-1:0] le;
    logic [FIT_W-1:0] cand_cost;
    logic [PATH_W-1:0] cand_path;
    logic any_dup, ins_en;
    logic clr, step, load;
    logic [N_SEL*PATH_W-1:0] out_pop_nxt;

    assign cand_cost = fitness[idx*FIT_W +: FIT_W];
    assign cand_path = population[idx*PATH_W +: PATH_W];

`ifdef SELECTION_DEDUP_EN
    logic [N_SEL-1:0] dup;
    for (genvar k = 0; k < N_SEL; k++) begin : g_dup
        assign dup[k] = lst[k].vld && (lst[k].path == cand_path);
    end
    assign any_dup = |dup;
`else
    assign any_dup = 1'b0;
`endif

    assign ins_en = !any_dup;

    // le[] is a thermometer code: valid entries form a sorted prefix, so the
    // first zero marks the insert position p; all-ones means discard.
    for (genvar k = 0; k < N_SEL; k++) begin : g_slot
        ga_sel_slot #(.FIT_W(FIT_W)) u_slot (
            .valid    (lst[k].vld),
            .cost     (lst[k].cost),
            .cand_cost(cand_cost),
            .le       (le[k])
        );

        if (k == 0) begin : g_head
            assign lst_nxt[k] = (ins_en && !le[k]) ? entry_t'{1'b1, cand_cost, cand_path} : lst[k];
        end else begin : g_tail
            assign lst_nxt[k] = (!ins_en || le[k]) ? lst[k]
                              : le[k-1]            ? entry_t'{1'b1, cand_cost, cand_path}
                                                   : lst[k-1];
        end

        assign out_pop_nxt[k*PATH_W +: PATH_W] = lst_nxt[k].vld ? lst_nxt[k].path : lst_nxt[0].path;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        clr       = 1'b0;
        step      = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_nxt = SCAN;
                clr       = 1'b1;
            end
            SCAN: begin
                step = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                    load      = 1'b1;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            lst            <= '0;
            sel_population <= '0;
            best_fitness   <= '0;
        end else begin
            state <= state_nxt;
            if (clr) begin
                idx <= '0;
                lst <= '0;
            end else if (step) begin
                lst <= lst_nxt;
                idx <= load ? '0 : idx + 1'b1;
            end
            // Load from lst_nxt so the final candidate is included.
            if (load) begin
                sel_population <= out_pop_nxt;
                best_fitness   <= lst_nxt[0].cost;
            end
        end
    end
endmodule

// File: doc/ga_selection.md
# ga_selection

Elitist selection stage of the genetic TSP engine: scans a 50-path population with per-path costs from the fitness stage and keeps the 10 lowest-cost paths. Output is packed in the 10 × 150-bit format consumed by the mutation stage. Its one-cycle `done` pulse is intended to drive the mutation stage's `start` directly.

## Interface
- `N_POP`, 50, population size (paths scanned)
- `N_SEL`, 10, paths kept
- `PATH_W`, 150, bits per path (opaque to this block)
- `FIT_W`, 16, bits per cost value (unsigned, lower is better)

- `clk`  in  1  clock; all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  level-sampled request; accepted only in IDLE
- `population`  in  N_POP*PATH_W  path i at `[i*PATH_W +: PATH_W]`
- `fitness`  in  N_POP*FIT_W  cost of path i at `[i*FIT_W +: FIT_W]`
- `sel_population`  out  N_SEL*PATH_W  slot k at `[k*PATH_W +: PATH_W]`; slot 0 is best
- `best_fitness`  out  FIT_W  cost of slot 0
- `done`  out  1  one-cycle pulse when outputs are valid

## Operation
- FSM: IDLE → SCAN → DONE → IDLE.
  - IDLE: `start`=1 → SCAN. On that same edge, clear the list: all N_SEL entries invalid, `idx`=0.
  - SCAN: one candidate per cycle, `idx` 0..N_POP-1. On the edge processing `idx`=N_POP-1 → DONE.
  - DONE: `done`=1 for exactly one cycle, then unconditional return to IDLE.
- Internal list: N_SEL entries {valid, cost, path}, kept in ascending cost order.
- Insertion of candidate c, each SCAN cycle:
  - p = number of valid entries with cost ≤ c.cost. Invalid entries count as +∞.
  - If p < N_SEL: entries p..N_SEL-2 shift to p+1..N_SEL-1, the old last entry is dropped, and c is written at p.
  - If p = N_SEL: c is discarded.
- Ties: an equal-cost candidate goes after existing entries, so the lower population index ranks better (stable).
- Output load: on the SCAN→DONE edge, the list is copied into the `sel_population`/`best_fitness` registers. Outputs stay stable until the next SCAN→DONE edge.
- Unfilled slots (possible only with dedup enabled) are filled with a copy of slot 0.
- `population` and `fitness` are not captured. The upstream stage holds them stable from the start-accept edge through the DONE cycle.
- `start` is ignored in SCAN and DONE. If `start` is still high in the cycle after DONE, a new run begins.
- Cost comparison is unsigned FIT_W-bit; no saturation or arithmetic beyond compare.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, `idx`=0, list invalid, `sel_population`=0, `best_fitness`=0, `done`=0.
- Latency: if `start` is sampled on edge E0, `done` is high during the cycle after edge E0+N_POP (51 edges with defaults).
- Throughput: one selection per N_POP+2 cycles when `start` is held high.
- Reset mid-SCAN: the run is abandoned, no `done` is produced, and outputs return to 0.
- Per-cycle critical path: N_SEL parallel comparators, then the insert/shift mux.

## Configuration
- `SELECTION_DEDUP_EN` defined: a candidate whose path bits equal a valid entry's path bits is discarded (N_SEL × PATH_W equality compare per cycle). Slots left unfilled at DONE are copied from slot 0.
- Undefined: duplicate paths are inserted like any other candidate. No path comparators are built.

## Test plan
- Costs = 1000−i for i=0..49, paths = i; `start` for one cycle.
  - Expect `done` exactly 51 edges after the start edge, slots 0..9 = paths 49..40, `best_fitness`=951.
- All costs = 7, paths = i.
  - Expect slots 0..9 = paths 0..9 (stable tie order), `best_fitness`=7.
- Costs pseudo-random from a 32-bit LFSR seed 0xACE1.
  - Expect the output to match a reference model's stable sort of the first 10 entries.
  - Expect `done` to be a single-cycle pulse.
- Assert `rst_n`=0 at `idx`=25, release, then restart with the ascending pattern.
  - Expect outputs 0 during reset, no `done` from the aborted run, and a correct result after restart.
- `start` held high continuously.
  - Expect `done` every 52 cycles.
  - Expect outputs to change only on each SCAN→DONE edge.
- Dedup build, all 50 paths identical (0x3), cost 5.
  - Expect all 10 slots = 0x3 and `best_fitness`=5.
  - Non-dedup build, same stimulus: all 10 slots = 0x3 as well, filled by insertion rather than replication.
